wb_ahb_bridge: RTL and testbench

//  Wishbone-classic slave to AHB-Lite master bridge. Sits between the management

---
 rtl/wb_ahb_bridge_pkg.sv | 29 ++
 rtl/wb_ahb_size_decode.sv | 29 ++
 rtl/wb_ahb_bridge.sv | 139 +++++++++++++
 tb/tb_wb_ahb_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ahb_bridge_pkg.sv
// Shared constants, FSM encoding and decode payload for the Wishbone-to-AHB-Lite bridge.
package wb_ahb_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_REJ  = 3'd3,
        ST_ACK  = 3'd4
    } state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] hsize;
        logic [1:0] addr_lsb;
    } size_dec_t;

endpackage

// File: rtl/wb_ahb_size_decode.sv
// Maps Wishbone byte selects to an AHB transfer size and the low address bits;
// non-contiguous or misaligned select patterns are flagged illegal.
module wb_ahb_size_decode
    import wb_ahb_bridge_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    output size_dec_t        dec_c
);

    always_comb begin
        dec_c.legal    = 1'b1;
        dec_c.hsize    = HSIZE_BYTE;
        dec_c.addr_lsb = 2'b00;
        case (sel)
            4'b1111: dec_c.hsize = HSIZE_WORD;
            4'b0011: dec_c.hsize = HSIZE_HALF;
            4'b1100: begin
                dec_c.hsize    = HSIZE_HALF;
                dec_c.addr_lsb = 2'b10;
            end
            4'b0001: dec_c.addr_lsb = 2'b00;
            4'b0010: dec_c.addr_lsb = 2'b01;
            4'b0100: dec_c.addr_lsb = 2'b10;
            4'b1000: dec_c.addr_lsb = 2'b11;
            default: dec_c.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_ahb_bridge.sv
// Wishbone-classic slave to AHB-Lite master bridge: one outstanding single transfer,
// window/select filtering, registered AHB and Wishbone outputs, sticky error flag.
module wb_ahb_bridge
    import wb_ahb_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [ADDR_W-1:0] WIN_MASK  = 32'hFF00_0000,
    parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [SEL_W-1:0]  wbs_sel_i,
    input  logic [ADDR_W-1:0] wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              bus_err_o,
    input  logic              bus_err_clr
);

    state_e            state_q, state_d;
    size_dec_t         dec_c;
    logic              win_hit_c;
    logic              abandon_q, abandon_d;
    logic              err_set;
    logic [ADDR_W-1:0] haddr_d;
    logic [1:0]        htrans_d;
    logic              hwrite_d;
    logic [2:0]        hsize_d;
    logic [DATA_W-1:0] hwdata_d;
    logic              ack_d;
    logic [DATA_W-1:0] dat_d;
    logic              bus_err_d;

    wb_ahb_size_decode u_size_decode (
        .sel   (wbs_sel_i),
        .dec_c (dec_c)
    );

    assign win_hit_c = (wbs_adr_i & WIN_MASK) == BASE_ADDR;

    // Next-state and next-output logic; abandon remembers a cyc drop so the ack stays suppressed.
    always_comb begin
        state_d   = state_q;
        abandon_d = abandon_q;
        err_set   = 1'b0;
        haddr_d   = HADDR;
        hwrite_d  = HWRITE;
        hsize_d   = HSIZE;
        hwdata_d  = HWDATA;
        ack_d     = 1'b0;
        dat_d     = wbs_dat_o;

        if ((state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_REJ) && !wbs_cyc_i) begin
            abandon_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    abandon_d = 1'b0;
                    if (win_hit_c && dec_c.legal) begin
                        state_d  = ST_ADDR;
                        haddr_d  = {wbs_adr_i[ADDR_W-1:2], dec_c.addr_lsb};
                        hwrite_d = wbs_we_i;
                        hsize_d  = dec_c.hsize;
                        hwdata_d = wbs_dat_i;
                    end else begin
                        state_d = ST_REJ;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) state_d = ST_ADDR == ST_ADDR ? ST_DATA : ST_ADDR;
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d = ST_ACK;
                    ack_d   = wbs_cyc_i && !abandon_d;
                    if (HRESP) begin
                        dat_d   = ERR_DATA;
                        err_set = 1'b1;
                    end else begin
                        dat_d = HWRITE ? '0 : HRDATA;
                    end
                end
            end
            ST_REJ: begin
                state_d = ST_ACK;
                ack_d   = wbs_cyc_i && !abandon_d;
                dat_d   = ERR_DATA;
                err_set = 1'b1;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        htrans_d  = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus_err_d = err_set ? 1'b1 : (bus_err_clr ? 1'b0 : bus_err_o);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            abandon_q <= 1'b0;
            HADDR     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HSIZE     <= '0;
            HWDATA    <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            bus_err_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            abandon_q <= abandon_d;
            HADDR     <= haddr_d;
            HTRANS    <= htrans_d;
            HWRITE    <= hwrite_d;
            HSIZE     <= hsize_d;
            HWDATA    <= hwdata_d;
            wbs_ack_o <= ack_d;
            wbs_dat_o <= dat_d;
            bus_err_o <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_wb_ahb_bridge.sv
// Scoreboard bench for wb_ahb_bridge: directed Wishbone requests against a small AHB slave model.
module tb_wb_ahb_bridge;
    import wb_ahb_bridge_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;
    logic        bus_err_o, bus_err_clr;

    wb_ahb_bridge dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .bus_err_o(bus_err_o), .bus_err_clr(bus_err_clr)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
    } ahb_exp_t;

    ahb_exp_t    ahb_q[$];
    logic [31:0] ack_q[$];
    int          errors = 0;
    int          checks = 0;

    int          slv_waits = 0;
    bit          slv_err   = 1'b0;
    logic [31:0] slv_rdata = '0;
    bit          prev_addr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // AHB slave: data phase gets slv_waits HREADY=0 cycles, last one carrying HRESP for a two-cycle error.
    initial begin : slave
        bit dphase;
        bit dfin;
        int dcnt;
        dphase = 1'b0;
        dfin   = 1'b0;
        dcnt   = 0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(posedge HCLK);
            #1;
            if (!HRESETn || dfin) begin
                dphase = 1'b0;
                dfin   = 1'b0;
            end
            if (prev_addr && HRESETn) begin
                dphase = 1'b1;
                dcnt   = 0;
            end
            if (dphase) begin
                if (dcnt < slv_waits) begin
                    HREADY = 1'b0;
                    HRESP  = slv_err && (dcnt == slv_waits - 1);
                end else begin
                    HREADY = 1'b1;
                    HRESP  = slv_err;
                    HRDATA = slv_rdata;
                    dfin   = 1'b1;
                end
                dcnt++;
            end else begin
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT accepts an address phase or acks.
    initial begin : monitor
        ahb_exp_t cur;
        bit       wchk;
        wchk = 1'b0;
        cur  = '0;
        forever begin
            @(negedge HCLK);
            prev_addr = HRESETn && (HTRANS == HTRANS_NONSEQ) && HREADY;
            if (wchk) begin
                if (cur.hwrite) chk("hwdata", HWDATA, cur.hwdata);
                if (HREADY) wchk = 1'b0;
            end
            if (prev_addr) begin
                if (ahb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected NONSEQ: got haddr 0x%08h expected none", HADDR);
                end else begin
                    cur = ahb_q.pop_front();
                    chk("haddr", HADDR, cur.haddr);
                    chk("hwrite", 32'(HWRITE), 32'(cur.hwrite));
                    chk("hsize", 32'(HSIZE), 32'(cur.hsize));
                    wchk = 1'b1;
                end
            end
            if (wbs_ack_o) begin
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected ack: got dat 0x%08h expected no ack", wbs_dat_o);
                end else begin
                    chk("ack dat", wbs_dat_o, ack_q.pop_front());
                end
            end
        end
    end

    task automatic drive_req(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                             input logic [31:0] dat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
    endtask

    task automatic release_req();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    // One acked transfer; latency counted from the IDLE cycle that samples stb.
    task automatic xfer(input string name, input bit we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input int waits, input bit err, input logic [31:0] rdata,
                        input bit ahb, input logic [31:0] haddr, input logic [2:0] hsize,
                        input logic [31:0] exp_dat, input int exp_lat, input int clr_at);
        int n;
        ahb_exp_t e;
        slv_waits = waits;
        slv_err   = err;
        slv_rdata = rdata;
        if (ahb) begin
            e.haddr  = haddr;
            e.hwrite = we;
            e.hsize  = hsize;
            e.hwdata = dat;
            ahb_q.push_back(e);
        end
        ack_q.push_back(exp_dat);
        @(posedge HCLK);
        #1;
        drive_req(we, sel, adr, dat);
        n = 0;
        while (n <= 20) begin
            @(posedge HCLK);
            #1;
            n++;
            bus_err_clr = (n == clr_at);
            if (wbs_ack_o) break;
        end
        bus_err_clr = 1'b0;
        release_req();
        chk({name, " latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic clear_err(input string name);
        @(posedge HCLK);
        #1;
        bus_err_clr = 1'b1;
        @(posedge HCLK);
        #1;
        bus_err_clr = 1'b0;
        chk({name, " bus_err cleared"}, 32'(bus_err_o), 32'd0);
    endtask

    initial begin : stimulus
        bit seen_ack;
        HRESETn     = 1'b0;
        bus_err_clr = 1'b0;
        wbs_sel_i   = '0;
        wbs_adr_i   = '0;
        wbs_dat_i   = '0;
        release_req();
        #2;
        chk("reset htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("reset ack", 32'(wbs_ack_o), 32'd0);
        chk("reset dat_o", wbs_dat_o, 32'd0);
        chk("reset bus_err", 32'(bus_err_o), 32'd0);
        chk("reset haddr", HADDR, 32'd0);
        #20;
        HRESETn = 1'b1;

        xfer("t1 word write", 1'b1, 4'b1111, 32'h3000_0010, 32'h1234_5678, 0, 1'b0, 32'h0,
             1'b1, 32'h3000_0010, HSIZE_WORD, 32'h0, 3, 0);
        xfer("t2 byte read", 1'b0, 4'b0100, 32'h3000_0020, 32'h0, 2, 1'b0, 32'hAABB_CCDD,
             1'b1, 32'h3000_0022, HSIZE_BYTE, 32'hAABB_CCDD, 5, 0);
        xfer("half write hi", 1'b1, 4'b1100, 32'h3000_0104, 32'hCAFE_0000, 0, 1'b0, 32'h0,
             1'b1, 32'h3000_0106, HSIZE_HALF, 32'h0, 3, 0);
        xfer("byte read lane3", 1'b0, 4'b1000, 32'h30FF_FFF0, 32'h0, 0, 1'b0, 32'h1122_3344,
             1'b1, 32'h30FF_FFF3, HSIZE_BYTE, 32'h1122_3344, 3, 0);
        chk("no error after good traffic", 32'(bus_err_o), 32'd0);

        xfer("t3 miss", 1'b0, 4'b1111, 32'h4000_0000, 32'h0, 0, 1'b0, 32'h0,
             1'b0, 32'h0, HSIZE_WORD, 32'hDEAD_BEEF, 2, 0);
        chk("t3 miss bus_err", 32'(bus_err_o), 32'd1);
        clear_err("t3 miss");
        xfer("t3 bad sel", 1'b0, 4'b0110, 32'h3000_0000, 32'h0, 0, 1'b0, 32'h0,
             1'b0, 32'h0, HSIZE_WORD, 32'hDEAD_BEEF, 2, 0);
        chk("t3 bad sel bus_err", 32'(bus_err_o), 32'd1);
        clear_err("t3 bad sel");

        xfer("t4 err write", 1'b1, 4'b0011, 32'h3000_0200, 32'h0000_BEEF, 1, 1'b1, 32'h0,
             1'b1, 32'h3000_0200, HSIZE_HALF, 32'hDEAD_BEEF, 4, 3);
        chk("t4 set beats clr", 32'(bus_err_o), 32'd1);
        clear_err("t4");

        // Master abandons the cycle during a stretched data phase.
        begin
            ahb_exp_t e;
            e.haddr  = 32'h3000_0030;
            e.hwrite = 1'b0;
            e.hsize  = HSIZE_WORD;
            e.hwdata = 32'h0;
            ahb_q.push_back(e);
            slv_waits = 3;
            slv_err   = 1'b0;
            slv_rdata = 32'h55AA_55AA;
            @(posedge HCLK);
            #1;
            drive_req(1'b0, 4'b1111, 32'h3000_0030, 32'h0);
            repeat (2) @(posedge HCLK);
            #1;
            release_req();
            seen_ack = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge HCLK);
                #1;
                if (wbs_ack_o) seen_ack = 1'b1;
            end
            chk("t5 ack suppressed", 32'(seen_ack), 32'd0);
            chk("t5 address issued", 32'(ahb_q.size()), 32'd0);
            chk("t5 bus_err", 32'(bus_err_o), 32'd0);
        end
        xfer("t5 follow-up read", 1'b0, 4'b1111, 32'h3000_0034, 32'h0, 0, 1'b0, 32'h0BAD_CAFE,
             1'b1, 32'h3000_0034, HSIZE_WORD, 32'h0BAD_CAFE, 3, 0);

        // Reset lands in the middle of an address phase.
        slv_waits = 0;
        @(posedge HCLK);
        #1;
        drive_req(1'b1, 4'b1111, 32'h3000_0040, 32'h0BAD_F00D);
        @(posedge HCLK);
        #1;
        chk("t6 in addr phase", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        #2;
        HRESETn = 1'b0;
        #1;
        chk("t6 async htrans", 32'(HTRANS), 32'(HTRANS_IDLE));
        chk("t6 async ack", 32'(wbs_ack_o), 32'd0);
        release_req();
        @(posedge HCLK);
        #3;
        HRESETn = 1'b1;
        xfer("t6 after reset", 1'b1, 4'b1111, 32'h3000_0010, 32'h1234_5678, 0, 1'b0, 32'h0,
             1'b1, 32'h3000_0010, HSIZE_WORD, 32'h0, 3, 0);

        repeat (3) @(posedge HCLK);
        #1;
        chk("ahb queue drained", 32'(ahb_q.size()), 32'd0);
        chk("ack queue drained", 32'(ack_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
